dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares the single-ported 64-bit data memory (1024 words) between two requesters.
- Requester 0 is the pipeline memory stage; requester 1 is the loader/debug port.
- It serialises requests with round-robin fairness and drives the memory's address, write data and read/write enables.
- It performs the address range check locally and returns read data, error and a completion pulse to the granted requester.

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported 64-bit data memory between the
// pipeline memory stage (requester 0) and the loader/debug port (requester 1).
// Requests are serialised round-robin, range-checked locally, and each one
// completes with a single-cycle done pulse carrying read data and error.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; arbitrate and latch the winning request
// ST_ACCESS | drive memory enables for the latched request, capture result
// ST_RESP   | pulse done to the owner, advance round-robin pointer, count
module dmem_arbiter #(
    parameter int MEM_DEPTH = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_wr,
    input  logic [63:0]      r0_addr,
    input  logic [63:0]      r0_wdata,
    output logic             r0_gnt,
    output logic             r0_done,
    output logic [63:0]      r0_rdata,
    output logic             r0_err,
    input  logic             r1_req,
    input  logic             r1_wr,
    input  logic [63:0]      r1_addr,
    input  logic [63:0]      r1_wdata,
    output logic             r1_gnt,
    output logic             r1_done,
    output logic [63:0]      r1_rdata,
    output logic             r1_err,
    output logic [63:0]      mem_Add,
    output logic             mem_wEn,
    output logic             mem_rEn,
    output logic [63:0]      mem_valA,
    input  logic [63:0]      mem_valM,
    input  logic             mem_err,
    output logic             busy,
    output logic [CNT_W-1:0] access_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr;
    logic             r_sel;
    logic             r_wr;
    logic [63:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [63:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_take;
    logic             w_pick;
    logic             w_in_range;
    logic             w_rd_ok;

    // Full 64-bit compare so that high address bits can never alias into range.
    assign w_in_range = (r_addr < 64'(MEM_DEPTH));
    assign w_rd_ok    = ~r_wr & w_in_range;

    // Next-state logic and arbitration: pointer breaks ties, lone requester wins outright.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_pick      = r_rr;
        case (r_state)
            ST_IDLE: begin
                if (r0_req && r1_req) begin
                    w_take = 1'b1;
                    w_pick = r_rr;
                end else if (r0_req) begin
                    w_take = 1'b1;
                    w_pick = 1'b0;
                end else if (r1_req) begin
                    w_take = 1'b1;
                    w_pick = 1'b1;
                end
                if (w_take) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus transaction latch, result capture and bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b0;
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_sel   <= w_pick;
                r_wr    <= w_pick ? r1_wr    : r0_wr;
                r_addr  <= w_pick ? r1_addr  : r0_addr;
                r_wdata <= w_pick ? r1_wdata : r0_wdata;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= w_rd_ok ? mem_valM : '0;
                r_err   <= ~w_in_range | mem_err;
            end
            if (r_state == ST_RESP) begin
                r_rr  <= ~r_sel;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Memory strobes, grants and the per-requester response steering.
    always_comb begin
        mem_wEn  = 1'b0;
        mem_rEn  = 1'b0;
        r0_gnt   = 1'b0;
        r1_gnt   = 1'b0;
        r0_done  = 1'b0;
        r1_done  = 1'b0;
        r0_rdata = '0;
        r1_rdata = '0;
        r0_err   = 1'b0;
        r1_err   = 1'b0;
        if (r_state == ST_ACCESS) begin
            mem_wEn = r_wr & w_in_range;
            mem_rEn = w_rd_ok;
        end
        if (r_state != ST_IDLE) begin
            r0_gnt = ~r_sel;
            r1_gnt = r_sel;
        end
        if (r_state == ST_RESP) begin
            if (r_sel) begin
                r1_done  = 1'b1;
                r1_rdata = r_rdata;
                r1_err   = r_err;
            end else begin
                r0_done  = 1'b1;
                r0_rdata = r_rdata;
                r0_err   = r_err;
            end
        end
    end

    assign mem_Add    = r_addr;
    assign mem_valA   = r_wdata;
    assign busy       = (r_state != ST_IDLE);
    assign access_cnt = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed transactions, expected responses
// queued at issue time and checked by a monitor thread on each done pulse.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_wr, r1_req, r1_wr;
    logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [63:0] r0_rdata, r1_rdata;
    logic [63:0] mem_Add, mem_valA, mem_valM;
    logic        mem_wEn, mem_rEn, mem_err;
    logic        busy;
    logic [15:0] access_cnt;

    logic [63:0] mem [0:1023];

    typedef struct {
        int          port;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_stop = 1'b0;
    int   cyc = 0;
    int   n_wen = 0;
    int   n_ren = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_DEPTH(1024), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_Add(mem_Add), .mem_wEn(mem_wEn), .mem_rEn(mem_rEn), .mem_valA(mem_valA),
        .mem_valM(mem_valM), .mem_err(mem_err),
        .busy(busy), .access_cnt(access_cnt)
    );

    // Memory model: combinational read while enabled.
    assign mem_valM = mem_rEn ? mem[mem_Add[9:0]] : 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe activity counters; any enable with an out-of-range address is illegal.
    always @(negedge clk) begin
        if (mem_wEn) n_wen <= n_wen + 1;
        if (mem_rEn) n_ren <= n_ren + 1;
        if ((mem_wEn || mem_rEn) && (mem_Add >= 64'd1024)) n_bad <= n_bad + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_resp(input int p, input logic [63:0] rd, input logic er);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        while (!mon_stop) begin
            @(negedge clk);
            if (!rst && (r0_done || r1_done)) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: r0_done=%0b r1_done=%0b, expected no done", r0_done, r1_done);
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", 64'({r0_done, r1_done}), (e.port == 0) ? 64'd2 : 64'd1);
                    chk("gnt_owner", 64'({r0_gnt, r1_gnt}), (e.port == 0) ? 64'd2 : 64'd1);
                    if (e.port == 0) begin
                        chk("r0_rdata", r0_rdata, e.rdata);
                        chk("r0_err", 64'(r0_err), 64'(e.err));
                        chk("r1_quiet", r1_rdata | 64'(r1_err), 64'd0);
                    end else begin
                        chk("r1_rdata", r1_rdata, e.rdata);
                        chk("r1_err", 64'(r1_err), 64'(e.err));
                        chk("r0_quiet", r0_rdata | 64'(r0_err), 64'd0);
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic req_txn(input int p, input logic wr, input logic [63:0] a,
                           input logic [63:0] d, input bit hold, output int lat);
        int t0;
        int n;
        bit seen;
        t0   = cyc;
        n    = 0;
        seen = 1'b0;
        if (p == 0) begin
            r0_wr = wr; r0_addr = a; r0_wdata = d; r0_req = 1'b1;
        end else begin
            r1_wr = wr; r1_addr = a; r1_wdata = d; r1_req = 1'b1;
        end
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if ((p == 0 && r0_done) || (p == 1 && r1_done)) seen = 1'b1;
        end
        lat = cyc - t0;
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout_r%0d: no done after %0d cycles, expected done", p, n);
        end
        if (!hold) begin
            if (p == 0) r0_req = 1'b0;
            else        r1_req = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int snap;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        rst = 1'b1;
        r0_req = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0;
        mem_err = 1'b0;

        fork
            monitor();
            forever begin
                @(posedge clk);
                if (mem_wEn) mem[mem_Add[9:0]] <= mem_valA;
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err}), 64'd0);
        chk("rst_rdata", r0_rdata | r1_rdata, 64'd0);
        chk("rst_mem_en", 64'({mem_wEn, mem_rEn}), 64'd0);
        chk("rst_mem_add", mem_Add, 64'd0);
        chk("rst_mem_vala", mem_valA, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(access_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // r0 writes 3025 to 101, r1 reads it back
        snap = n_wen;
        expect_resp(0, 64'd0, 1'b0);
        req_txn(0, 1'b1, 64'd101, 64'd3025, 1'b0, lat);
        chk("r0_latency", 64'(lat), 64'd2);
        @(negedge clk);
        chk("wen_one_cycle", 64'(n_wen - snap), 64'd1);
        expect_resp(1, 64'd3025, 1'b0);
        req_txn(1, 1'b0, 64'd101, 64'd0, 1'b0, lat);
        @(negedge clk);
        chk("cnt_after_2", 64'(access_cnt), 64'd2);

        // Simultaneous requests held high: grants must alternate 0,1,0,1
        expect_resp(0, 64'hC0DE_0000_0000_00C9, 1'b0);
        expect_resp(1, 64'd0, 1'b0);
        expect_resp(0, 64'd4576, 1'b0);
        expect_resp(1, 64'd4576, 1'b0);
        fork
            begin : p0_thread
                int l0;
                req_txn(0, 1'b0, 64'd201, 64'd0, 1'b1, l0);
                req_txn(0, 1'b0, 64'd401, 64'd0, 1'b0, l0);
            end
            begin : p1_thread
                int l1;
                req_txn(1, 1'b1, 64'd401, 64'd4576, 1'b1, l1);
                req_txn(1, 1'b0, 64'd401, 64'd0, 1'b0, l1);
            end
        join
        @(negedge clk);
        chk("cnt_after_6", 64'(access_cnt), 64'd6);

        // Out-of-range read never strobes memory
        snap = n_wen + n_ren;
        expect_resp(1, 64'd0, 1'b1);
        req_txn(1, 1'b0, 64'd2905, 64'd0, 1'b0, lat);
        @(negedge clk);
        chk("oor_read_no_strobe", 64'(n_wen + n_ren - snap), 64'd0);
        chk("cnt_after_7", 64'(access_cnt), 64'd7);

        // Boundary: 1024 is out of range, 1023 is the last valid word
        snap = n_wen + n_ren;
        expect_resp(0, 64'd0, 1'b1);
        req_txn(0, 1'b1, 64'd1024, 64'hDEAD, 1'b0, lat);
        @(negedge clk);
        chk("oor_write_no_strobe", 64'(n_wen + n_ren - snap), 64'd0);
        expect_resp(0, 64'hC0DE_0000_0000_03FF, 1'b0);
        req_txn(0, 1'b0, 64'd1023, 64'd0, 1'b0, lat);
        @(negedge clk);
        chk("cnt_after_9", 64'(access_cnt), 64'd9);

        // Memory-reported error on a valid read still returns the data
        mem_err = 1'b1;
        expect_resp(0, 64'd3025, 1'b1);
        req_txn(0, 1'b0, 64'd101, 64'd0, 1'b0, lat);
        mem_err = 1'b0;
        @(negedge clk);
        chk("cnt_after_10", 64'(access_cnt), 64'd10);

        // rst during ACCESS of an r0 read aborts it (pointer is 1 beforehand)
        r0_wr = 1'b0; r0_addr = 64'd500; r0_req = 1'b1;
        n = 0;
        while (!r0_gnt && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_access", 64'({r0_gnt, mem_rEn, busy}), 64'd7);
        rst = 1'b1;
        r0_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_no_done", 64'({r0_done, r1_done}), 64'd0);
        // rst clears the counter; the aborted read adds nothing
        chk("abort_cnt", 64'(access_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_still_idle", 64'({busy, r0_done}), 64'd0);
        expect_resp(1, 64'hC0DE_0000_0000_03FF, 1'b0);
        req_txn(1, 1'b0, 64'd1023, 64'd0, 1'b0, lat);
        @(negedge clk);
        chk("cnt_after_abort", 64'(access_cnt), 64'd1);

        // Pointer returns to 0 on reset: with contention r0 wins first
        expect_resp(0, 64'd0, 1'b0);
        req_txn(0, 1'b1, 64'd7, 64'd77, 1'b0, lat);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_resp(0, 64'd77, 1'b0);
        expect_resp(1, 64'd77, 1'b0);
        fork
            begin : q0_thread
                int l2;
                req_txn(0, 1'b0, 64'd7, 64'd0, 1'b0, l2);
            end
            begin : q1_thread
                int l3;
                req_txn(1, 1'b0, 64'd7, 64'd0, 1'b0, l3);
            end
        join
        @(negedge clk);
        chk("cnt_after_rr", 64'(access_cnt), 64'd2);

        repeat (3) @(negedge clk);
        chk("illegal_strobes", 64'(n_bad), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        mon_stop = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
